// File: rtl/uart_mmio_core.sv
// Memory-mapped 8N1 UART core: req/gnt/rvalid register port, transmitter, oversampled receiver,
// RX FIFO and level interrupt. Define UART_LOOPBACK_EN to feed the receiver from tx_o.
module uart_mmio_core #(
    parameter int unsigned CLK_FREQ      = 25_000_000,
    parameter int unsigned BAUD_RATE     = 57600,
    parameter logic [31:0] BASE_ADDR     = 32'h10000000,
    parameter int unsigned RX_FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic        mem_gnt_o,
    output logic        mem_rvalid_o,
    output logic [31:0] mem_rdata_o,
    input  logic        rx_i,
    output logic        tx_o,
    output logic        irq_o,
    input  logic        irq_ack_i
);

    localparam int unsigned DIV = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned PW  = $clog2(RX_FIFO_DEPTH);

    localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   LVL_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]   LVL_FULL = (PW + 1)'(RX_FIFO_DEPTH);

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    tx_state_e         tx_state_q, tx_state_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
    logic [2:0]        tx_bit_q, tx_bit_d;
    logic [7:0]        tx_shift_q, tx_shift_d;

    rx_state_e         rx_state_q, rx_state_d;
    logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic              rx_s1_q, rx_s2_q, rx_prev_q;
    logic              rx_line;
    logic              push_req, frame_set;

    logic [7:0]        fifo_mem [RX_FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]       count_q, count_d;
    logic              fifo_full, fifo_empty, push_ok, pop;

    logic              overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic              irq_q, irq_d;
    logic              rvalid_q;
    logic [31:0]       rdata_q, rdata_d;

    logic              addr_hit, sel_tx, sel_rx, sel_st;
    logic              tx_busy, tx_start, rd, st_rd;
    logic              unused_wdata;

    assign unused_wdata = ^mem_wdata_i[31:8];

`ifdef UART_LOOPBACK_EN
    logic unused_rx;
    assign unused_rx = rx_i;
    assign rx_line   = tx_o;
`else
    assign rx_line = rx_i;
`endif

    // Bus decode; only a TXDATA write during a frame is back-pressured.
    assign addr_hit   = mem_addr_i[31:4] == BASE_ADDR[31:4];
    assign sel_tx     = addr_hit && mem_addr_i[3:0] == 4'h0;
    assign sel_rx     = addr_hit && mem_addr_i[3:0] == 4'h4;
    assign sel_st     = addr_hit && mem_addr_i[3:0] == 4'h8;
    assign tx_busy    = tx_state_q != TxIdle;
    assign mem_gnt_o  = mem_req_i && !(mem_we_i && sel_tx && tx_busy);
    assign tx_start   = mem_gnt_o && mem_we_i && sel_tx;
    assign rd         = mem_gnt_o && !mem_we_i;
    assign st_rd      = rd && sel_st;
    assign fifo_full  = count_q == LVL_FULL;
    assign fifo_empty = count_q == '0;
    assign pop        = rd && sel_rx && !fifo_empty;
    assign push_ok    = push_req && (!fifo_full || pop);

    assign mem_rvalid_o = rvalid_q;
    assign mem_rdata_o  = rdata_q;
    assign irq_o        = irq_q;

    always_comb begin
        rdata_d = '0;
        if (rd && sel_rx && !fifo_empty) begin
            rdata_d = {24'b0, fifo_mem[rd_ptr_q]};
        end else if (st_rd) begin
            rdata_d = {27'b0, frame_err_q, overrun_q, fifo_full, !fifo_empty, tx_busy};
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_o       = 1'b1;
        unique case (tx_state_q)
            TxIdle: begin
                if (tx_start) begin
                    tx_state_d = TxStart;
                    tx_cnt_d   = DIV_M1;
                    tx_shift_d = mem_wdata_i[7:0];
                end
            end
            TxStart: begin
                tx_o = 1'b0;
                if (tx_cnt_q == '0) begin
                    tx_state_d = TxData;
                    tx_cnt_d   = DIV_M1;
                    tx_bit_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_ONE;
                end
            end
            TxData: begin
                tx_o = tx_shift_q[0];
                if (tx_cnt_q == '0) begin
                    tx_cnt_d   = DIV_M1;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TxStop;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_ONE;
                end
            end
            TxStop: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = TxIdle;
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_ONE;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    // Receiver samples mid-bit: half a bit after the falling edge, then every DIV cycles.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        push_req   = 1'b0;
        frame_set  = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = HALF_M1;
                end
            end
            RxStart: begin
                if (rx_cnt_q == '0) begin
                    rx_state_d = rx_s2_q ? RxIdle : RxData;
                    rx_cnt_d   = DIV_M1;
                    rx_bit_d   = '0;
                end else begin
                    rx_cnt_d = rx_cnt_q - CNT_ONE;
                end
            end
            RxData: begin
                if (rx_cnt_q == '0) begin
                    rx_cnt_d   = DIV_M1;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CNT_ONE;
                end
            end
            RxStop: begin
                if (rx_cnt_q == '0) begin
                    rx_state_d = RxIdle;
                    push_req   = rx_s2_q;
                    frame_set  = !rx_s2_q;
                end else begin
                    rx_cnt_d = rx_cnt_q - CNT_ONE;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // New error events win over a same-cycle STATUS read so they are never lost.
    always_comb begin
        wr_ptr_d    = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d     = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + LVL_ONE;
        end else if (!push_ok && pop) begin
            count_d = count_q - LVL_ONE;
        end
        overrun_d   = (push_req && fifo_full && !pop) || (overrun_q && !st_rd);
        frame_err_d = frame_set || (frame_err_q && !st_rd);
        irq_d       = push_ok || (irq_q && !irq_ack_i);
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= rx_shift_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state_q  <= TxIdle;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            rx_state_q  <= RxIdle;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            irq_q       <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_s1_q     <= rx_line;
            rx_s2_q     <= rx_s1_q;
            rx_prev_q   <= rx_s2_q;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            irq_q       <= irq_d;
            rvalid_q    <= mem_gnt_o;
            rdata_q     <= rdata_d;
        end
    end

endmodule

// File: tb/tb_uart_mmio_core.sv
// Self-checking bench for uart_mmio_core: scoreboard of expected bus responses plus
// direct checks of the serial line, status bits and interrupt.
module tb_uart_mmio_core;

    localparam int unsigned DIV  = 20;
    localparam logic [31:0] BASE = 32'h10000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rx = 1'b1;
    logic        tx;
    logic        irq;
    logic        irq_ack = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t  sb_q[$];
    string tag_q[$];

    uart_mmio_core #(
        .CLK_FREQ     (2_000_000),
        .BAUD_RATE    (100_000),
        .BASE_ADDR    (BASE),
        .RX_FIFO_DEPTH(8)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .mem_req_i   (mem_req),
        .mem_we_i    (mem_we),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_gnt_o   (mem_gnt),
        .mem_rvalid_o(mem_rvalid),
        .mem_rdata_o (mem_rdata),
        .rx_i        (rx),
        .tx_o        (tx),
        .irq_o       (irq),
        .irq_ack_i   (irq_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Every response must arrive exactly one cycle after its grant with the predicted data.
    always @(negedge clk) begin
        if (rst_n && mem_rvalid) begin
            if (sb_q.size() == 0) begin
                check_eq("rvalid_spurious", 32'd1, 32'd0);
            end else begin
                exp_t  e;
                string t;
                e = sb_q.pop_front();
                t = tag_q.pop_front();
                check_eq({t, "_lat"}, cyc, e.cyc);
                check_eq(t, mem_rdata, e.data);
            end
        end
    end

    // Caller is 1 ns after a posedge; returns 1 ns after the posedge following the grant.
    task automatic bus_xfer(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp, output int gcyc);
        int n;
        mem_req   = 1'b1;
        mem_we    = we;
        mem_addr  = addr;
        mem_wdata = wdata;
        gcyc      = -1;
        n         = 0;
        while (gcyc < 0 && n < 1000) begin
            #1;
            if (mem_gnt) begin
                gcyc = cyc;
                sb_q.push_back('{data: exp, cyc: cyc + 1});
                tag_q.push_back(tag);
            end
            @(posedge clk);
            #1;
            n++;
        end
        mem_req = 1'b0;
        mem_we  = 1'b0;
        if (gcyc < 0) check_eq({tag, "_gnt_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        int g;
        bus_xfer(tag, 1'b0, addr, '0, exp, g);
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
        int g;
        bus_xfer(tag, 1'b1, addr, data, '0, g);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        wait_cycles(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(DIV);
        end
        rx = stop_bit;
        wait_cycles(DIV);
        rx = 1'b1;
        wait_cycles(4);
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        wait_cycles(1);
        irq_ack = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1;
        logic [9:0] frame;
        wait_cycles(3);
        check_eq("rst_gnt", {31'b0, mem_gnt}, 32'd0);
        check_eq("rst_rvalid", {31'b0, mem_rvalid}, 32'd0);
        check_eq("rst_rdata", mem_rdata, 32'd0);
        check_eq("rst_tx", {31'b0, tx}, 32'd1);
        check_eq("rst_irq", {31'b0, irq}, 32'd0);
        rst_n = 1'b1;
        wait_cycles(2);
        rd("status_rst", BASE + 32'h8, 32'h0);

`ifdef UART_LOOPBACK_EN
        rx = 1'b0;
        wr("lb_tx", BASE, 32'h7E);
        wait_cycles(11 * DIV);
        check_eq("lb_irq", {31'b0, irq}, 32'd1);
        rd("lb_status", BASE + 32'h8, 32'h2);
        rd("lb_rxdata", BASE + 32'h4, 32'h7E);
        rd("lb_status2", BASE + 32'h8, 32'h0);
`else
        // TX 0x55 with a back-pressured second write.
        bus_xfer("tx_wr1", 1'b1, BASE, 32'h55, 32'h0, t0);
        check_eq("tx_start_edge", {31'b0, tx}, 32'd0);
        frame = {1'b1, 8'h55, 1'b0};
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    while (cyc < t0 + 1 + k * DIV + DIV / 2) @(negedge clk);
                    check_eq($sformatf("tx_bit%0d", k), {31'b0, tx}, {31'b0, frame[k]});
                end
            end
            begin
                wait_cycles(3);
                bus_xfer("tx_wr2", 1'b1, BASE, 32'hFF, 32'h0, t1);
                check_eq("tx_hold_cycle", t1, t0 + 1 + 10 * DIV);
            end
        join
        rd("status_busy", BASE + 32'h8, 32'h1);
        wait_cycles(11 * DIV);

        // Single RX frame.
        send_frame(8'hA3, 1'b1);
        check_eq("rx_irq", {31'b0, irq}, 32'd1);
        rd("rx_status", BASE + 32'h8, 32'h2);
        rd("rx_data", BASE + 32'h4, 32'hA3);
        rd("rx_status_empty", BASE + 32'h8, 32'h0);
        pulse_ack();
        check_eq("irq_ack", {31'b0, irq}, 32'd0);

        // Overflow the FIFO by one frame.
        for (int i = 0; i < 9; i++) send_frame(8'h30 + 8'(i), 1'b1);
        check_eq("ovf_irq", {31'b0, irq}, 32'd1);
        rd("ovf_status", BASE + 32'h8, 32'h0E);
        rd("ovf_status2", BASE + 32'h8, 32'h06);
        for (int i = 0; i < 8; i++) rd($sformatf("fifo%0d", i), BASE + 32'h4, 32'h30 + i);
        rd("rx_empty_read", BASE + 32'h4, 32'h0);
        rd("status_drained", BASE + 32'h8, 32'h0);
        pulse_ack();

        // Framing error, then a short glitch.
        send_frame(8'h5A, 1'b0);
        check_eq("ferr_irq", {31'b0, irq}, 32'd0);
        rd("ferr_status", BASE + 32'h8, 32'h10);
        rd("ferr_clear", BASE + 32'h8, 32'h0);
        rx = 1'b0;
        wait_cycles(6);
        rx = 1'b1;
        wait_cycles(2 * DIV);
        check_eq("glitch_irq", {31'b0, irq}, 32'd0);
        rd("glitch_status", BASE + 32'h8, 32'h0);

        // Unmapped offsets and decode misses.
        rd("unmapped_c", BASE + 32'hC, 32'h0);
        rd("miss_rd", 32'h20000004, 32'h0);
        wr("miss_wr", 32'h20000000, 32'hAA);
        check_eq("miss_wr_tx", {31'b0, tx}, 32'd1);
        rd("txdata_rd", BASE, 32'h0);

        // Reset mid-frame aborts TX and flushes RX.
        send_frame(8'h42, 1'b1);
        wr("abort_tx", BASE, 32'h00);
        wait_cycles(2 * DIV);
        check_eq("pre_rst_tx", {31'b0, tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("abort_tx_line", {31'b0, tx}, 32'd1);
        check_eq("abort_irq", {31'b0, irq}, 32'd0);
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(2);
        rd("abort_status", BASE + 32'h8, 32'h0);
`endif

        wait_cycles(3);
        check_eq("sb_drain", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
